// File: rtl/output_display_if.sv
// Bus bundle between the CPU result port and the seven-segment display stage.
// master drives the result bus and strobes; slave (the display) drives AN/SEG.
interface output_display_if;
  logic [32:1] Output_Data;
  logic        step;
  logic        blank;
  logic [7:0]  AN;
  logic [7:0]  SEG;

  modport master (output Output_Data, step, blank, input AN, SEG);
  modport slave  (input Output_Data, step, blank, output AN, SEG);
endinterface

// File: rtl/output_display.sv
// Captures the CPU result bus on a step strobe and scans its eight hex nibbles
// onto a common-anode 7-segment display. Optional macro DISP_LZ_BLANK_EN hides leading zeros.
module output_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  output_display_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PCNT_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);

  logic          s1, s2, s3;
  logic          cap_en;
  logic [32:1]   hold;
  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic [3:0]    nib;
  logic          suppress;
  logic [7:0]    an_nxt;
  logic [7:0]    seg_nxt;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 8'hC0;
      4'h1:    hex7 = 8'hF9;
      4'h2:    hex7 = 8'hA4;
      4'h3:    hex7 = 8'hB0;
      4'h4:    hex7 = 8'h99;
      4'h5:    hex7 = 8'h92;
      4'h6:    hex7 = 8'h82;
      4'h7:    hex7 = 8'hF8;
      4'h8:    hex7 = 8'h80;
      4'h9:    hex7 = 8'h90;
      4'hA:    hex7 = 8'h88;
      4'hB:    hex7 = 8'h83;
      4'hC:    hex7 = 8'hC6;
      4'hD:    hex7 = 8'hA1;
      4'hE:    hex7 = 8'h86;
      4'hF:    hex7 = 8'h8E;
      default: hex7 = 8'hFF;
    endcase
  endfunction

  // step is asynchronous to clk: two-flop synchronizer, third flop for edge detect
  assign cap_en = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      hold <= '0;
    end else begin
      s1 <= bus.step;
      s2 <= s1;
      s3 <= s2;
      if (cap_en) hold <= bus.Output_Data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= 3'd0;
    end else if (pcnt == PCNT_MAX) begin
      pcnt <= '0;
      idx  <= idx + 3'd1;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  always_comb begin
    nib = 4'(hold >> {idx, 2'b00});
`ifdef DISP_LZ_BLANK_EN
    // digit 0 always lit so an all-zero value still shows a single 0
    suppress = (idx != 3'd0) && ((hold >> {idx, 2'b00}) == 32'd0);
`else
    suppress = 1'b0;
`endif
    an_nxt  = 8'hFF;
    seg_nxt = 8'hFF;
    if (!(bus.blank || (pcnt < BLANK_LIM) || suppress)) begin
      an_nxt  = ~(8'b1 << idx);
      seg_nxt = hex7(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.AN  <= 8'hFF;
      bus.SEG <= 8'hFF;
    end else begin
      bus.AN  <= an_nxt;
      bus.SEG <= seg_nxt;
    end
  end
endmodule

// File: doc/output_display.md
# output_display

Downstream display stage for the CPU's 32-bit `Output_Data` bus. Captures the bus on a step strobe (the same manual step switch that clocks the CPU), holds it, and time-multiplexes the eight hex nibbles onto an 8-digit common-anode seven-segment display. Runs on the board free-running clock, independent of the CPU step clock, with anti-ghosting blanking between digits.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_CYC`, 500: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.

Ports:
- `clk`  input  1  board clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `Output_Data`  input  32 (`[32:1]`)  CPU result bus; stable while `step` is high.
- `step`  input  1  asynchronous capture strobe (SW[0] step level).
- `blank`  input  1  synchronous; 1 forces all anodes off.
- `AN`  output  8  digit enables, active-low; `AN[k]` = digit k, digit 0 rightmost.
- `SEG`  output  8  segments, active-low, `{dp,g,f,e,d,c,b,a}`.

## Operation
- Step synchronizer: `step` → two flops `s1`,`s2` → third flop `s3`; `cap_en = s2 & ~s3` (rising edge only, one cycle).
- Capture: on `cap_en`, `hold <= Output_Data`. No other writes. Holding `step` high captures once.
- Prescaler `pcnt`: counts 0..`SCAN_DIV`-1, wraps to 0. On wrap, digit index `idx` (3 bits) increments, 7→0.
- Digit k shows nibble `hold[4k+4:4k+1]`.
- Hex decode (active-low, dp bit = 1 always): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- `AN` next = 8'hFF if `blank`, or `pcnt < BLANK_CYC`, or digit suppressed (see Configuration); else `~(8'b1 << idx)`.
- `SEG` next = decode of current nibble; when `AN` next is all-ones, `SEG` next = 8'hFF.
- Exactly one anode low at any time, or none.
- Reset values: `hold`=0, `s1..s3`=0, `pcnt`=0, `idx`=0, `AN`=8'hFF, `SEG`=8'hFF.
- Reset mid-capture: sync chain cleared. A `step` already high on release produces a capture three cycles later, because `s3` starts at 0.

## Timing
- `AN`/`SEG` are registered and lag `pcnt`/`idx` by one cycle.
- `step` rising before clock edge N: `s1` set at N, `s2` at N+1, `hold` updated at N+2 (`s3` set at N+2). New data is visible on digit k at the first slot of k that begins after N+2, plus one cycle.
- `step` pulses shorter than one clock period may be missed. Pulses that return to 0 and rise again each capture once, provided each level is held ≥ 2 cycles.
- `blank` asserted/deasserted at edge N → `AN` changes at N+1.
- Full scan period = 8·`SCAN_DIV` cycles. Lit time per slot = `SCAN_DIV`−`BLANK_CYC` cycles.
- `cap_en` on the same cycle as an `idx` wrap: both take effect; no priority conflict.

## Configuration
- `DISP_LZ_BLANK_EN` defined: leading-zero suppression. Digit k (k ≥ 1) is suppressed (`AN`/`SEG` all-ones for its slot) when nibbles k..7 of `hold` are all zero. Digit 0 is never suppressed, so `hold`=0 shows a single "0".
- Undefined: all eight digits are always shown, including leading zeros.

## Test plan
Bench uses `SCAN_DIV`=4, `BLANK_CYC`=1.
- Reset, then idle: `AN`=FF, `SEG`=FF during reset. After release, slot 0 cycle 0 has `AN`=FF; cycles 1–3 have `AN`=FE, `SEG`=C0.
- `Output_Data`=32'h1234ABCD, pulse `step` high 3 cycles → `hold` updated 2 cycles after sync. Digits 0..7 read `SEG` A1,C6,83,88,99,B0,A4,F9 with `AN` FE,FD,…,7F in order. Scan repeats every 32 cycles.
- `step` held high 20 cycles while `Output_Data` changes to 32'hFFFFFFFF mid-pulse → `hold` keeps the first-captured value. A second rise captures the new value.
- Assert `blank` for 10 cycles → `AN`=FF, `SEG`=FF from the next edge. Scan `idx` keeps advancing, so after release the digit shown matches an unblanked reference model.
- `DISP_LZ_BLANK_EN` on, `hold`=32'h00000A05 → digits 0,1,2 lit (92,C0,88); digits 3–7 `AN`=FF. `hold`=0 → only digit 0 lit, `SEG`=C0. Same stimulus with the macro off → all 8 digits lit.
- Assert `rst_n` low mid-slot with `hold`=32'hDEADBEEF → `AN`/`SEG` go FF immediately (asynchronous). `hold` is 0 after release; the display shows 0 on all digits (macro off).
